// File: rtl/control_unit_pkg.sv
// Shared encodings for the EC-2 style control unit: state codes,
// opcodes and accumulator input select values.
package control_unit_pkg;

  typedef enum logic [3:0] {
    ST_START  = 4'b0000,
    ST_FETCH  = 4'b0001,
    ST_DECODE = 4'b0010,
    ST_LOAD   = 4'b1000,
    ST_STORE  = 4'b1001,
    ST_ADD    = 4'b1010,
    ST_SUB    = 4'b1011,
    ST_IN     = 4'b1100,
    ST_JZ     = 4'b1101,
    ST_JPOS   = 4'b1110,
    ST_HALT   = 4'b1111
  } state_e;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  // Maps an opcode to the execute state that carries it out.
  // The encoding works out to {1'b1, opcode}, but naming each case
  // keeps the opcode table readable in one place.
  function automatic state_e execState(input logic [2:0] op);
    state_e s;
    case (op)
      OP_LOAD:  s = ST_LOAD;
      OP_STORE: s = ST_STORE;
      OP_ADD:   s = ST_ADD;
      OP_SUB:   s = ST_SUB;
      OP_IN:    s = ST_IN;
      OP_JZ:    s = ST_JZ;
      OP_JPOS:  s = ST_JPOS;
      default:  s = ST_HALT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control unit and the datapath: status inputs
// (user strobe, opcode, accumulator flags) and the control strobes
// plus the observable state / next state.
interface control_unit_if;

  logic       enter;
  logic [2:0] ir;
  logic       aeq0;
  logic       apos;

  logic       irLoad;
  logic       jmpMux;
  logic       pcLoad;
  logic       memInst;
  logic       memWr;
  logic       aLoad;
  logic       sub;
  logic       halt;
  logic [1:0] aSel;
  logic [3:0] state;
  logic [3:0] nextState;

  // The controller side drives strobes and reads datapath status.
  modport master (
    input  enter, ir, aeq0, apos,
    output irLoad, jmpMux, pcLoad, memInst, memWr, aLoad, sub, halt,
    output aSel, state, nextState
  );

  // The datapath side supplies status and consumes strobes.
  modport slave (
    output enter, ir, aeq0, apos,
    input  irLoad, jmpMux, pcLoad, memInst, memWr, aLoad, sub, halt,
    input  aSel, state, nextState
  );

endinterface

// File: rtl/control_unit.sv
// Start -> Fetch -> Decode -> Execute sequencer for the 8-bit
// single-accumulator datapath. Strobes depend on the current state,
// with the IN/JZ/JPOS strobes also following their status inputs.
module control_unit
  import control_unit_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  control_unit_if.master  ctrl_io
);

  state_e     state_q;
  state_e     state_d;

  logic       irLoad;
  logic       jmpMux;
  logic       pcLoad;
  logic       memInst;
  logic       memWr;
  logic       aLoad;
  logic       sub;
  logic       halt;
  logic [1:0] aSel;

  // State register; reset forces START without waiting for a clock edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode; every strobe defaults low so
  // unreachable encodings fall back to START with nothing asserted.
  always_comb begin
    state_d = ST_START;
    irLoad  = 1'b0;
    jmpMux  = 1'b0;
    pcLoad  = 1'b0;
    memInst = 1'b0;
    memWr   = 1'b0;
    aLoad   = 1'b0;
    sub     = 1'b0;
    halt    = 1'b0;
    aSel    = ASEL_ALU;

    case (state_q)
      ST_START: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
        irLoad  = 1'b1;
        pcLoad  = 1'b1;
      end
      ST_DECODE: begin
        state_d = execState(ctrl_io.ir);
        memInst = 1'b1;
      end
      ST_LOAD: begin
        memInst = 1'b1;
        aLoad   = 1'b1;
        aSel    = ASEL_MEM;
      end
      ST_STORE: begin
        memInst = 1'b1;
        memWr   = 1'b1;
      end
      ST_ADD: begin
        aLoad = 1'b1;
      end
      ST_SUB: begin
        aLoad = 1'b1;
        sub   = 1'b1;
      end
      ST_IN: begin
        aSel    = ASEL_IN;
        aLoad   = ctrl_io.enter;
        state_d = ctrl_io.enter ? ST_START : ST_IN;
      end
      ST_JZ: begin
        jmpMux = 1'b1;
        pcLoad = ctrl_io.aeq0;
      end
      ST_JPOS: begin
        jmpMux = 1'b1;
        pcLoad = ctrl_io.apos;
      end
      ST_HALT: begin
        halt    = 1'b1;
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_START;
      end
    endcase
  end

  assign ctrl_io.irLoad    = irLoad;
  assign ctrl_io.jmpMux    = jmpMux;
  assign ctrl_io.pcLoad    = pcLoad;
  assign ctrl_io.memInst   = memInst;
  assign ctrl_io.memWr     = memWr;
  assign ctrl_io.aLoad     = aLoad;
  assign ctrl_io.sub       = sub;
  assign ctrl_io.halt      = halt;
  assign ctrl_io.aSel      = aSel;
  assign ctrl_io.state     = state_q;
  assign ctrl_io.nextState = state_d;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed instruction sequences followed by
// random traffic, checked against an instruction-level model through a
// scoreboard queue drained by an independent monitor.
module tb_control_unit;

  logic clk;
  logic rst;

  control_unit_if bus ();

  control_unit dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .ctrl_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: expected observation vector per cycle plus a label.
  // Vector layout: {state, nextState, irLoad, jmpMux, pcLoad, memInst,
  //                 memWr, aLoad, sub, halt, aSel}
  logic [17:0] expQ[$];
  string       nameQ[$];

  int testsRun    = 0;
  int testsFailed = 0;

  // Instruction-level model: phase 0 = start, 1 = fetch, 2 = decode,
  // 3 = executing modelOp.
  int         modelPhase   = 0;
  logic [2:0] modelOp      = 3'b000;
  int         pendingPhase = 0;
  logic [2:0] pendingOp    = 3'b000;

  function automatic logic [3:0] phaseCode(input int ph, input logic [2:0] op);
    case (ph)
      0:       return 4'b0000;
      1:       return 4'b0001;
      2:       return 4'b0010;
      default: return {1'b1, op};
    endcase
  endfunction

  function automatic int phaseAfter(input int ph, input logic [2:0] op, input logic enter);
    if (ph < 3) return ph + 1;
    if (op == 3'b100) return enter ? 0 : 3;
    if (op == 3'b111) return 3;
    return 0;
  endfunction

  function automatic logic [9:0] modelStrobes(input int ph, input logic [2:0] op,
                                              input logic enter, input logic aeq0,
                                              input logic apos);
    logic irL, jm, pcL, mi, mw, aL, sb, hl;
    logic [1:0] as;
    irL = 0; jm = 0; pcL = 0; mi = 0; mw = 0; aL = 0; sb = 0; hl = 0; as = 2'b00;
    if (ph == 1) begin
      irL = 1; pcL = 1;
    end else if (ph == 2) begin
      mi = 1;
    end else if (ph == 3) begin
      case (op)
        3'b000: begin mi = 1; aL = 1; as = 2'b10; end
        3'b001: begin mi = 1; mw = 1; end
        3'b010: aL = 1;
        3'b011: begin aL = 1; sb = 1; end
        3'b100: begin as = 2'b01; aL = enter; end
        3'b101: begin jm = 1; pcL = aeq0; end
        3'b110: begin jm = 1; pcL = apos; end
        default: hl = 1;
      endcase
    end
    return {irL, jm, pcL, mi, mw, aL, sb, hl, as};
  endfunction

  // One clock cycle of stimulus: inputs (and reset) change just after the
  // rising edge, and the expected observation for this cycle is queued.
  task automatic applyStimulus(input logic [2:0] irV, input logic enterV,
                               input logic aeq0V, input logic aposV,
                               input logic rstV, input string tag);
    int nextPh;
    logic [2:0] nextOp;
    @(posedge clk);
    #1;
    modelPhase = pendingPhase;
    modelOp    = pendingOp;
    bus.ir     = irV;
    bus.enter  = enterV;
    bus.aeq0   = aeq0V;
    bus.apos   = aposV;
    rst        = rstV;
    if (rstV) modelPhase = 0;
    nextOp = (modelPhase == 2) ? irV : modelOp;
    nextPh = phaseAfter(modelPhase, nextOp, enterV);
    expQ.push_back({phaseCode(modelPhase, modelOp), phaseCode(nextPh, nextOp),
                    modelStrobes(modelPhase, modelOp, enterV, aeq0V, aposV)});
    nameQ.push_back(tag);
    pendingPhase = rstV ? 0 : nextPh;
    pendingOp    = nextOp;
  endtask

  task automatic runInstr(input logic [2:0] op, input logic z, input logic p, input string tag);
    for (int i = 0; i < 4; i++) applyStimulus(op, 1'b0, z, p, 1'b0, tag);
  endtask

  task automatic checkOutput(input string name, input logic [17:0] expV, input logic [17:0] actV);
    testsRun++;
    if (actV !== expV) begin
      testsFailed++;
      $display("[TB] FAIL %s: got state=%b next=%b strobes=%b, required state=%b next=%b strobes=%b",
               name, actV[17:14], actV[13:10], actV[9:0], expV[17:14], expV[13:10], expV[9:0]);
    end
  endtask

  // Monitor: samples the DUT on the falling edge, away from state updates.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        checkOutput(nameQ.pop_front(), expQ.pop_front(),
                    {bus.state, bus.nextState, bus.irLoad, bus.jmpMux, bus.pcLoad,
                     bus.memInst, bus.memWr, bus.aLoad, bus.sub, bus.halt, bus.aSel});
      end
    end
  end

  initial begin
    rst       = 1'b1;
    bus.ir    = 3'b000;
    bus.enter = 1'b0;
    bus.aeq0  = 1'b0;
    bus.apos  = 1'b0;

    applyStimulus(3'b000, 0, 0, 0, 1, "reset");
    applyStimulus(3'b000, 0, 0, 0, 1, "reset");

    runInstr(3'b000, 0, 0, "load");
    runInstr(3'b001, 0, 0, "store");
    runInstr(3'b010, 0, 0, "add");
    runInstr(3'b011, 0, 0, "sub");

    for (int i = 0; i < 3; i++) applyStimulus(3'b100, 0, 0, 0, 0, "in_fetch");
    for (int i = 0; i < 3; i++) applyStimulus(3'b100, 0, 0, 0, 0, "in_wait");
    applyStimulus(3'b100, 1, 0, 0, 0, "in_enter");

    runInstr(3'b101, 1, 0, "jz_taken");
    runInstr(3'b101, 0, 1, "jz_not_taken");
    runInstr(3'b110, 0, 1, "jpos_taken");
    runInstr(3'b110, 1, 0, "jpos_not_taken");

    for (int i = 0; i < 3; i++) applyStimulus(3'b111, 0, 0, 0, 0, "halt_fetch");
    for (int i = 0; i < 50; i++) applyStimulus(3'($urandom_range(7)), 1, 1, 1, 0, "halt_hold");
    applyStimulus(3'b000, 0, 0, 0, 1, "halt_async_reset");
    applyStimulus(3'b000, 0, 0, 0, 0, "halt_release");

    applyStimulus(3'b010, 0, 0, 0, 0, "pre_decode");
    applyStimulus(3'b010, 0, 0, 0, 0, "pre_decode");
    applyStimulus(3'b010, 0, 0, 0, 1, "decode_async_reset");
    runInstr(3'b010, 0, 0, "resume_add");

    for (int i = 0; i < 400; i++) begin
      applyStimulus(3'($urandom_range(7)), ($urandom_range(3) == 0),
                    1'($urandom_range(1)), 1'($urandom_range(1)),
                    ($urandom_range(39) == 0), "random");
    end

    repeat (2) @(posedge clk);
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
